// File: rtl/wb_prefetch_buffer.sv
// Single-line read prefetch buffer between the Wishbone arbiter and the SPI SRAM controller.
// Read misses become linear incrementing bursts; hits are served locally; writes pass through.
module wb_prefetch_buffer #(
  parameter int ADDR_WIDTH = 23,
  parameter int LINE_BYTES = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic [ADDR_WIDTH-1:0] wbs_adr_i,
  input  logic                  wbs_we_i,
  input  logic [7:0]            wbs_dat_i,
  input  logic [2:0]            wbs_cti_i,
  input  logic [1:0]            wbs_bte_i,
  output logic                  wbs_ack_o,
  output logic                  wbs_err_o,
  output logic                  wbs_rty_o,
  output logic [7:0]            wbs_dat_o,
  output logic                  wbm_cyc_o,
  output logic                  wbm_stb_o,
  output logic [ADDR_WIDTH-1:0] wbm_adr_o,
  output logic                  wbm_we_o,
  output logic [7:0]            wbm_dat_o,
  output logic [2:0]            wbm_cti_o,
  output logic [1:0]            wbm_bte_o,
  input  logic                  wbm_ack_i,
  input  logic                  wbm_err_i,
  input  logic                  wbm_rty_i,
  input  logic [7:0]            wbm_dat_i
);

  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int TAG_W = ADDR_WIDTH - OFF_W;
  localparam logic [OFF_W-1:0] LAST_IDX = OFF_W'(LINE_BYTES - 1);

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HIT,
    S_FILL,
    S_RESP,
    S_ERR,
    S_WRITE
  } state_t;

  state_t state, next_state;

  logic [7:0]            line_data [LINE_BYTES];
  logic [TAG_W-1:0]      tag;
  logic                  valid;
  logic                  flush_pending;
  logic                  abandon;
  logic [OFF_W-1:0]      fill_idx;
  logic [ADDR_WIDTH-1:0] req_adr;
  logic [7:0]            req_dat;
  logic                  ack_q, err_q, rty_q;
  logic [7:0]            rd_dat_q;

  logic [TAG_W-1:0] in_tag, req_tag;
  logic [OFF_W-1:0] in_off, req_off;
  logic             resp_pend, req, rd_hit, beat_fail, beat_ok, fill_last, wr_hit, keep_resp;

  // Upstream cti/bte carry no meaning here: every access is handled as classic.
  logic unused_cti_bte;
  assign unused_cti_bte = ^{wbs_cti_i, wbs_bte_i};

  assign in_tag  = wbs_adr_i[ADDR_WIDTH-1:OFF_W];
  assign in_off  = wbs_adr_i[OFF_W-1:0];
  assign req_tag = req_adr[ADDR_WIDTH-1:OFF_W];
  assign req_off = req_adr[OFF_W-1:0];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= next_state;
  end

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    next_state = state;
    resp_pend  = ack_q | err_q | rty_q;
    // A request is not accepted while the previous response pulse is still on the bus.
    req        = wbs_cyc_i & wbs_stb_i & ~resp_pend;
    rd_hit     = valid && (tag == in_tag) && !flush_i;
    beat_fail  = wbm_err_i | wbm_rty_i;
    beat_ok    = wbm_ack_i & ~beat_fail;
    fill_last  = (fill_idx == LAST_IDX);
    wr_hit     = valid && (tag == req_tag);
    keep_resp  = wbs_cyc_i & ~abandon;

    case (state)
      S_IDLE: begin
        if (req) begin
          if (wbs_we_i)    next_state = S_WRITE;
          else if (rd_hit) next_state = S_HIT;
          else             next_state = S_FILL;
        end
      end
      S_FILL: begin
        if (beat_fail)                next_state = S_ERR;
        else if (beat_ok && fill_last) next_state = S_RESP;
      end
      S_WRITE: begin
        if (wbm_ack_i || beat_fail) next_state = S_IDLE;
      end
      S_HIT, S_RESP, S_ERR: next_state = S_IDLE;
      default:              next_state = S_IDLE;
    endcase

    wbm_cyc_o = (state == S_FILL) || (state == S_WRITE);
    wbm_stb_o = wbm_cyc_o;
    wbm_we_o  = (state == S_WRITE);
    wbm_bte_o = 2'b00;
    wbm_adr_o = '0;
    wbm_dat_o = '0;
    wbm_cti_o = CTI_CLASSIC;
    if (state == S_FILL) begin
      wbm_adr_o = {tag, fill_idx};
      wbm_cti_o = fill_last ? CTI_END : CTI_INCR;
    end else if (state == S_WRITE) begin
      wbm_adr_o = req_adr;
      wbm_dat_o = req_dat;
    end

    // Dropping cyc kills a response that is already queued.
    wbs_ack_o = ack_q & wbs_cyc_i;
    wbs_err_o = err_q & wbs_cyc_i;
    wbs_rty_o = rty_q & wbs_cyc_i;
    wbs_dat_o = rd_dat_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tag           <= '0;
      valid         <= 1'b0;
      flush_pending <= 1'b0;
      abandon       <= 1'b0;
      fill_idx      <= '0;
      req_adr       <= '0;
      req_dat       <= '0;
      ack_q         <= 1'b0;
      err_q         <= 1'b0;
      rty_q         <= 1'b0;
      rd_dat_q      <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      rty_q <= 1'b0;
      if (flush_i && state != S_FILL) valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (req) begin
            req_adr <= wbs_adr_i;
            req_dat <= wbs_dat_i;
            abandon <= 1'b0;
            if (!wbs_we_i) begin
              if (rd_hit) begin
                ack_q    <= 1'b1;
                rd_dat_q <= line_data[in_off];
              end else begin
                tag           <= in_tag;
                valid         <= 1'b0;
                fill_idx      <= '0;
                flush_pending <= 1'b0;
              end
            end
          end
        end
        S_FILL: begin
          if (flush_i)    flush_pending <= 1'b1;
          if (!wbs_cyc_i) abandon       <= 1'b1;
          if (beat_fail) begin
            valid <= 1'b0;
            err_q <= wbm_err_i & keep_resp;
            rty_q <= ~wbm_err_i & keep_resp;
          end else if (wbm_ack_i) begin
            fill_idx <= fill_idx + 1'b1;
            if (fill_last) begin
              valid    <= ~(flush_pending | flush_i);
              ack_q    <= keep_resp;
              // The last byte is still on wbm_dat_i; the array is written on this same edge.
              rd_dat_q <= (req_off == LAST_IDX) ? wbm_dat_i : line_data[req_off];
            end
          end
        end
        S_WRITE: begin
          if (!wbs_cyc_i) abandon <= 1'b1;
          if (beat_fail) begin
            err_q <= wbm_err_i & keep_resp;
            rty_q <= ~wbm_err_i & keep_resp;
          end else if (wbm_ack_i) begin
            ack_q <= keep_resp;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the line storage has no reset; valid=0 makes its contents irrelevant after reset.
  always_ff @(posedge clk_i) begin
    if (state == S_FILL && beat_ok) begin
      line_data[fill_idx] <= wbm_dat_i;
    end else if (state == S_WRITE && beat_ok && wr_hit) begin
      line_data[req_off] <= req_dat;
    end
  end

endmodule
